// File: rtl/mesm6_serial.sv
// mesm6_serial: 8N1 UART slave on the MMU data bus with circular TX/RX FIFOs
// and a registered level interrupt toward the PIC.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a byte in the TX FIFO
// TX_START | driving the start bit (0)
// TX_DATA  | shifting 8 data bits, LSB first
// TX_STOP  | driving the stop bit (1)
// RX_IDLE  | waiting for a synchronised 1->0 edge
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling the stop bit
// RX_BREAK | framing error seen, waiting for the line to return high
module mesm6_serial #(
  parameter int DIV_RESET  = 86,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        irq,
  input  logic [14:0] addr,
  input  logic        read,
  input  logic        write,
  output logic [47:0] rdata,
  input  logic [47:0] wdata,
  output logic        done,
  input  logic        rxd,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic        r_done, r_irq, r_rxovr, r_ferr, r_txdrop;
  logic [47:0] r_rdata, w_rmux;
  logic [1:0]  r_ctrl, w_a;
  logic [15:0] r_div;
  logic        w_acc, w_wr, w_rd, w_clr, w_txbusy, w_unused;
  logic [6:0]  w_status;

  logic [7:0]  r_txf_mem [FIFO_DEPTH];
  logic [7:0]  r_rxf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_txf_wp, r_txf_rp, r_rxf_wp, r_rxf_rp;
  logic [AW:0] r_txf_cnt, r_rxf_cnt;
  logic        w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
  logic        w_txf_push, w_tx_drop, w_rxf_pop, w_rxf_push;
  logic [7:0]  w_txf_head;

  tx_state_t   r_tx_st, w_tx_nxt;
  logic [15:0] r_tx_tmr, w_tx_tmr, r_tx_div, w_tx_div;
  logic [2:0]  r_tx_bit, w_tx_bit;
  logic [7:0]  r_tx_sh, w_tx_sh;
  logic        r_txd, w_txd, w_tx_pop;

  rx_state_t   r_rx_st, w_rx_nxt;
  logic [15:0] r_rx_tmr, w_rx_tmr, r_rx_div, w_rx_div, w_rx_half;
  logic [2:0]  r_rx_bit, w_rx_bit;
  logic [7:0]  r_rx_sh, w_rx_sh;
  logic        r_rx_s1, r_rx_s2, r_rx_prev, w_rx_push, w_rx_ferr;

  assign w_unused    = ^{addr[14:2], wdata[47:16]};
  assign w_a         = addr[1:0];
  assign w_acc       = (read | write) & ~r_done;
  assign w_wr        = w_acc & write;
  assign w_rd        = w_acc & read & ~write;
  assign w_clr       = w_rd & (w_a == 2'd1);
  assign w_txf_full  = (r_txf_cnt == FULL_CNT);
  assign w_txf_empty = (r_txf_cnt == '0);
  assign w_rxf_full  = (r_rxf_cnt == FULL_CNT);
  assign w_rxf_empty = (r_rxf_cnt == '0);
  assign w_txf_push  = w_wr & (w_a == 2'd0) & ~w_txf_full;
  assign w_tx_drop   = w_wr & (w_a == 2'd0) & w_txf_full;
  assign w_rxf_pop   = w_rd & (w_a == 2'd0) & ~w_rxf_empty;
  // A bus pop in the same cycle frees the slot the RX push needs.
  assign w_rxf_push  = w_rx_push & (~w_rxf_full | w_rxf_pop);
  assign w_txf_head  = r_txf_mem[r_txf_rp];
  assign w_txbusy    = (r_tx_st != TX_IDLE);
  assign w_status    = {w_txbusy, r_txdrop, r_ferr, r_rxovr, ~w_rxf_empty, w_txf_empty, w_txf_full};
  assign w_rx_half   = 16'(({1'b0, r_div} + 17'd1) >> 1);

  assign irq   = r_irq;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign txd   = r_txd;

  always_comb begin
    w_rmux = '0;
    case (w_a)
      2'd0:    if (!w_rxf_empty) w_rmux[7:0] = r_rxf_mem[r_rxf_rp];
      2'd1:    w_rmux[6:0] = w_status;
      2'd2:    w_rmux[1:0] = r_ctrl;
      default: w_rmux[15:0] = r_div;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_ctrl   <= '0;
      r_div    <= 16'(DIV_RESET);
      r_irq    <= 1'b0;
      r_txdrop <= 1'b0;
      r_rxovr  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_done  <= w_acc;
      r_rdata <= w_rd ? w_rmux : '0;
      if (w_wr && w_a == 2'd2) r_ctrl <= wdata[1:0];
      if (w_wr && w_a == 2'd3) r_div  <= wdata[15:0];
      r_txdrop <= w_tx_drop | (r_txdrop & ~w_clr);
      r_rxovr  <= (w_rx_push & w_rxf_full & ~w_rxf_pop) | (r_rxovr & ~w_clr);
      r_ferr   <= w_rx_ferr | (r_ferr & ~w_clr);
      r_irq    <= (r_ctrl[0] & ~w_rxf_empty) | (r_ctrl[1] & w_txf_empty & ~w_txbusy);
    end
  end

  always_ff @(posedge clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wp] <= wdata[7:0];
    if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txf_wp  <= '0;
      r_txf_rp  <= '0;
      r_txf_cnt <= '0;
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_rxf_cnt <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_tx_pop)   r_txf_rp <= r_txf_rp + 1'b1;
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
      if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + 1'b1;
      r_txf_cnt <= r_txf_cnt + {{AW{1'b0}}, w_txf_push} - {{AW{1'b0}}, w_tx_pop};
      r_rxf_cnt <= r_rxf_cnt + {{AW{1'b0}}, w_rxf_push} - {{AW{1'b0}}, w_rxf_pop};
    end
  end

  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_tmr = r_tx_tmr;
    w_tx_div = r_tx_div;
    w_tx_bit = r_tx_bit;
    w_tx_sh  = r_tx_sh;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE: if (!w_txf_empty) begin
        w_tx_pop = 1'b1;
        w_tx_nxt = TX_START;
        w_tx_sh  = w_txf_head;
        w_tx_div = r_div;
        w_tx_tmr = r_div;
      end
      TX_START: if (r_tx_tmr == '0) begin
        w_tx_nxt = TX_DATA;
        w_tx_bit = 3'd0;
        w_tx_tmr = r_tx_div;
      end else w_tx_tmr = r_tx_tmr - 16'd1;
      TX_DATA: if (r_tx_tmr == '0) begin
        w_tx_tmr = r_tx_div;
        if (r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
        else begin
          w_tx_bit = r_tx_bit + 3'd1;
          w_tx_sh  = {1'b0, r_tx_sh[7:1]};
        end
      end else w_tx_tmr = r_tx_tmr - 16'd1;
      TX_STOP: if (r_tx_tmr == '0) begin
        // Chain straight into the next start bit when more data is queued.
        if (!w_txf_empty) begin
          w_tx_pop = 1'b1;
          w_tx_nxt = TX_START;
          w_tx_sh  = w_txf_head;
          w_tx_div = r_div;
          w_tx_tmr = r_div;
        end else w_tx_nxt = TX_IDLE;
      end else w_tx_tmr = r_tx_tmr - 16'd1;
      default: w_tx_nxt = TX_IDLE;
    endcase
    case (w_tx_nxt)
      TX_START: w_txd = 1'b0;
      TX_DATA:  w_txd = w_tx_sh[0];
      default:  w_txd = 1'b1;
    endcase
  end

  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_rx_tmr  = r_rx_tmr;
    w_rx_div  = r_rx_div;
    w_rx_bit  = r_rx_bit;
    w_rx_sh   = r_rx_sh;
    w_rx_push = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_st)
      RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_nxt = RX_START;
        w_rx_div = r_div;
        w_rx_tmr = w_rx_half;
      end
      RX_START: if (r_rx_tmr == '0) begin
        if (r_rx_s2) w_rx_nxt = RX_IDLE;
        else begin
          w_rx_nxt = RX_DATA;
          w_rx_bit = 3'd0;
          w_rx_tmr = r_rx_div;
        end
      end else w_rx_tmr = r_rx_tmr - 16'd1;
      RX_DATA: if (r_rx_tmr == '0) begin
        w_rx_sh  = {r_rx_s2, r_rx_sh[7:1]};
        w_rx_tmr = r_rx_div;
        if (r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
        else w_rx_bit = r_rx_bit + 3'd1;
      end else w_rx_tmr = r_rx_tmr - 16'd1;
      RX_STOP: if (r_rx_tmr == '0) begin
        if (r_rx_s2) begin
          w_rx_push = 1'b1;
          w_rx_nxt  = RX_IDLE;
        end else begin
          w_rx_ferr = 1'b1;
          w_rx_nxt  = RX_BREAK;
        end
      end else w_rx_tmr = r_rx_tmr - 16'd1;
      RX_BREAK: if (r_rx_s2) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_st   <= TX_IDLE;
      r_tx_tmr  <= '0;
      r_tx_div  <= '0;
      r_tx_bit  <= '0;
      r_tx_sh   <= '0;
      r_txd     <= 1'b1;
      r_rx_st   <= RX_IDLE;
      r_rx_tmr  <= '0;
      r_rx_div  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_tx_st   <= w_tx_nxt;
      r_tx_tmr  <= w_tx_tmr;
      r_tx_div  <= w_tx_div;
      r_tx_bit  <= w_tx_bit;
      r_tx_sh   <= w_tx_sh;
      r_txd     <= w_txd;
      r_rx_st   <= w_rx_nxt;
      r_rx_tmr  <= w_rx_tmr;
      r_rx_div  <= w_rx_div;
      r_rx_bit  <= w_rx_bit;
      r_rx_sh   <= w_rx_sh;
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end
endmodule

// File: tb/tb_mesm6_serial.sv
// tb_mesm6_serial: directed register vectors plus hand-written TX, loopback,
// RX overrun/framing and mid-frame reset sequences for mesm6_serial.
module tb_mesm6_serial;
  logic        clk = 1'b0, reset_n = 1'b0, read = 1'b0, write = 1'b0;
  logic        rxd_drv = 1'b1, loop_en = 1'b0;
  logic [14:0] addr = '0;
  logic [47:0] wdata = '0;
  logic [47:0] rdata;
  logic        irq, done, txd, rxd_w;
  int          n_checks = 0, n_errors = 0;
  logic        tx_wave [0:255];

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [47:0] wd;
    logic [47:0] exp;
    logic        ck_irq;
    logic        exp_irq;
  } vec_t;
  vec_t vecs [14];

  assign rxd_w = loop_en ? txd : rxd_drv;
  always #5 clk = ~clk;

  mesm6_serial #(.DIV_RESET(86), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .addr(addr), .read(read),
    .write(write), .rdata(rdata), .wdata(wdata), .done(done), .rxd(rxd_w), .txd(txd)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_acc(input logic wr, input logic [1:0] a, input logic [47:0] d,
                         output logic [47:0] rd);
    logic got;
    got = 1'b0;
    @(negedge clk);
    addr = {13'd0, a}; wdata = d; write = wr; read = ~wr;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    rd = rdata;
    read = 1'b0; write = 1'b0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL bus_done_timeout actual=0 expected=1");
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [47:0] d);
    logic [47:0] dummy;
    bus_acc(1'b1, a, d, dummy);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [47:0] d);
    bus_acc(1'b0, a, 48'd0, d);
  endtask

  // Waits for the start bit on txd, then records txd once per clock.
  task automatic capture_tx(input int ncyc, output logic got);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      if (txd == 1'b0) got = 1'b1;
    end
    if (got) begin
      tx_wave[0] = txd;
      for (int i = 1; i < ncyc; i++) begin
        @(posedge clk); #1;
        tx_wave[i] = txd;
      end
    end
  endtask

  // 8N1 frame with DIV=3: every bit is held for 4 clocks.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (4) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] rd;
    logic        got;
    int          nbad;
    logic [7:0]  t3 [5];

    vecs[0]  = '{1'b0, 2'd1, 48'd0, 48'h02, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 48'd0, 48'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd3, 48'd0, 48'd86, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 48'd0, 48'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 48'hABCD_0000_0002, 48'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 48'd0, 48'h02, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 2'd3, 48'h1234_5678_9ABC, 48'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd3, 48'd0, 48'h9ABC, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 48'hFF, 48'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 48'd0, 48'h02, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 48'd3, 48'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd3, 48'd0, 48'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 48'd0, 48'h0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd2, 48'd0, 48'h00, 1'b1, 1'b0};
    t3[0] = 8'h01; t3[1] = 8'h02; t3[2] = 8'h03; t3[3] = 8'h04; t3[4] = 8'h05;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_txd", txd, 1); chk("rst_irq", irq, 0);
    chk("rst_done", done, 0); chk("rst_rdata", rdata, 0);

    // Register vectors: reset values, write/read-back, ignored STATUS write, irq.
    for (int i = 0; i < 14; i++) begin
      bus_acc(vecs[i].wr, vecs[i].a, vecs[i].wd, rd);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      if (vecs[i].ck_irq) chk($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
      chk($sformatf("vec%0d_rdata_idle", i), rdata, 0);
    end

    // Single frame 0xA5, DIV=3: exact 4-clock bit cells, then idle.
    bus_wr(2'd3, 48'd3);
    bus_wr(2'd0, 48'hA5);
    fork
      capture_tx(48, got);
      begin
        repeat (10) @(posedge clk);
        bus_rd(2'd1, rd);
        chk("tx_a5_status_busy", rd, 48'h42);
      end
    join
    chk("tx_a5_started", got, 1);
    nbad = 0;
    for (int i = 0; i < 48; i++)
      if (tx_wave[i] !== ((i < 40) ? frame_bit(8'hA5, i / 4) : 1'b1)) nbad++;
    chk("tx_a5_wave_bad_cycles", nbad, 0);
    bus_rd(2'd1, rd);
    chk("tx_a5_status_after", rd, 48'h02);

    // Byte 1 moves straight into the shifter, so 0x02..0x05 fill the FIFO
    // and the sixth write is the one dropped.
    fork
      capture_tx(208, got);
      begin
        for (int i = 1; i <= 6; i++) bus_wr(2'd0, 48'(i));
        bus_rd(2'd1, rd);
        chk("tx_drop_status_set", rd, 48'h61);
        bus_rd(2'd1, rd);
        chk("tx_drop_status_clr", rd, 48'h41);
      end
    join
    chk("tx_b2b_started", got, 1);
    nbad = 0;
    for (int i = 0; i < 208; i++)
      if (tx_wave[i] !== ((i < 200) ? frame_bit(t3[i / 40], (i % 40) / 4) : 1'b1)) nbad++;
    chk("tx_b2b_wave_bad_cycles", nbad, 0);

    // Loopback with RXIE.
    bus_wr(2'd2, 48'h1);
    loop_en = 1'b1;
    bus_wr(2'd0, 48'h3C);
    chk("loop_irq_before", irq, 0);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (irq) got = 1'b1;
    end
    chk("loop_irq_rise", got, 1);
    bus_rd(2'd0, rd);
    chk("loop_rx_byte", rd, 48'h3C);
    @(posedge clk); #1;
    chk("loop_irq_fall", irq, 0);
    repeat (10) @(posedge clk);
    loop_en = 1'b0;

    // Overrun: five frames into a four-entry FIFO.
    send_rx(8'h11, 1'b1); send_rx(8'h22, 1'b1); send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1); send_rx(8'h55, 1'b1);
    repeat (10) @(posedge clk);
    bus_rd(2'd1, rd);
    chk("rx_ovr_status", rd, 48'h0E);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(2'd0, rd);
      chk($sformatf("rx_ovr_byte%0d", i), rd, 48'(8'h11 * i));
    end
    bus_rd(2'd0, rd);
    chk("rx_empty_read", rd, 0);
    bus_rd(2'd1, rd);
    chk("rx_ovr_cleared", rd, 48'h02);

    // Framing error: stop bit low, byte discarded.
    send_rx(8'h66, 1'b0);
    repeat (10) @(posedge clk);
    bus_rd(2'd1, rd);
    chk("rx_ferr_status", rd, 48'h12);
    bus_rd(2'd0, rd);
    chk("rx_ferr_no_push", rd, 0);

    // Reset in the middle of a TX frame while irq is high.
    send_rx(8'h77, 1'b1);
    repeat (10) @(posedge clk);
    chk("pre_reset_irq", irq, 1);
    bus_wr(2'd0, 48'h81);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #1;
      if (txd == 1'b0) got = 1'b1;
    end
    chk("pre_reset_tx_start", got, 1);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 1); chk("midrst_irq", irq, 0);
    chk("midrst_done", done, 0); chk("midrst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_rd(2'd3, rd); chk("post_rst_div", rd, 48'd86);
    bus_rd(2'd2, rd); chk("post_rst_ctrl", rd, 0);
    bus_rd(2'd1, rd); chk("post_rst_status", rd, 48'h02);
    bus_rd(2'd0, rd); chk("post_rst_data", rd, 0);
    repeat (50) @(posedge clk); #1;
    chk("post_rst_txd_idle", txd, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
